// File: rtl/bind_nway_stream_mapper.sv
// bind_nway_stream_mapper
// Binds NUM_OPERANDS source hypervectors word by word: streams one word of
// every operand into the bind kernel with first/last framing, waits for the
// kernel result and writes it to the destination hypervector in DPRAM.
// Optional feature: define BIND_NWAY_MAPPER_PERF_CNT_EN to add the
// busy_cycles output (cycles spent with done low, saturating).
module bind_nway_stream_mapper #(
   parameter int HV_DATA_WIDTH          = 32,
   parameter int HV_ADDRESS_WIDTH       = 20,
   parameter int NUM_OPERANDS           = 2,
   parameter int MAX_HYPERVECTOR_LENGTH = 4,
   parameter int RD_LATENCY             = 1
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic                                         valid,
   input  logic [NUM_OPERANDS*HV_ADDRESS_WIDTH-1:0]     hv_base,
   input  logic [HV_ADDRESS_WIDTH-1:0]                  hv_dest,
   input  logic [$clog2(MAX_HYPERVECTOR_LENGTH+1)-1:0]  hv_len,
   output logic                                         we_n,
   output logic [HV_ADDRESS_WIDTH-1:0]                  address,
   output logic [HV_DATA_WIDTH-1:0]                     data_wr,
   input  logic [HV_DATA_WIDTH-1:0]                     data_rd,
   output logic                                         done,
   output logic                                         k_valid,
   output logic                                         k_first,
   output logic                                         k_last,
   output logic [HV_DATA_WIDTH-1:0]                     k_data_in,
   input  logic [HV_DATA_WIDTH-1:0]                     k_data_out,
   input  logic                                         k_ready,
   input  logic                                         k_done
`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
   ,
   output logic [31:0]                                  busy_cycles
`endif
);

   localparam int AW  = HV_ADDRESS_WIDTH;
   localparam int LW  = $clog2(MAX_HYPERVECTOR_LENGTH + 1);
   localparam int OPW = $clog2(NUM_OPERANDS);
   localparam logic [LW-1:0]  MAX_LEN = LW'(MAX_HYPERVECTOR_LENGTH);
   localparam logic [OPW-1:0] OP_LAST = OPW'(NUM_OPERANDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_K, S_READ, S_DRAIN, S_WAIT_DONE, S_WRITE, S_FINISH
   } state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   base_in  [NUM_OPERANDS];
   logic [AW-1:0]   base_reg [NUM_OPERANDS];
   logic [AW-1:0]   dest_reg;
   logic [LW-1:0]   len_reg, off_reg, off_inc, len_clamped;
   logic [OPW-1:0]  op_reg;
   // read tag: [2]=valid, [1]=first operand, [0]=last operand
   logic [2:0]      rd_tag_reg;
   logic [2:0]      tag_pipe_reg [RD_LATENCY];
   logic [2:0]      tag_out;
   logic            accept, issue_rd, wr_start, wr_end, finish;

   // Unpack the flat operand base bus into one address per operand
   for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_base
      assign base_in[gi] = hv_base[gi*AW +: AW];
   end

   assign len_clamped = (hv_len > MAX_LEN) ? MAX_LEN : hv_len;
   assign off_inc     = off_reg + LW'(1);

   // Returned words are framed straight from the tag pipe, no extra register
   assign tag_out   = tag_pipe_reg[RD_LATENCY-1];
   assign k_valid   = tag_out[2];
   assign k_first   = tag_out[2] & tag_out[1];
   assign k_last    = tag_out[2] & tag_out[0];
   assign k_data_in = tag_out[2] ? data_rd : '0;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= S_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state and per-cycle control strobes. The operand-0 read is launched
   // on the k_ready cycle itself so the first address appears one cycle
   // after the kernel handshake; S_READ then issues operands 1..N-1.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      issue_rd   = 1'b0;
      wr_start   = 1'b0;
      wr_end     = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (valid) begin
               accept     = 1'b1;
               state_next = S_WAIT_K;
            end
         end
         S_WAIT_K: begin
            // zero-length requests are caught here from the latched length
            if (len_reg == '0) begin
               state_next = S_FINISH;
            end else if (k_ready) begin
               issue_rd   = 1'b1;
               state_next = S_READ;
            end
         end
         S_READ: begin
            issue_rd = 1'b1;
            if (op_reg == OP_LAST) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (k_last) state_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (k_done) begin
               wr_start   = 1'b1;
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_end     = 1'b1;
            state_next = (off_inc == len_reg) ? S_FINISH : S_WAIT_K;
         end
         S_FINISH: begin
            finish     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Request latch, word/operand counters, DPRAM address/data and write strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done       <= 1'b1;
         we_n       <= 1'b1;
         address    <= '1;
         data_wr    <= '0;
         base_reg   <= '{default: '0};
         dest_reg   <= '0;
         len_reg    <= '0;
         off_reg    <= '0;
         op_reg     <= '0;
         rd_tag_reg <= '0;
      end else begin
         we_n       <= ~wr_start;
         rd_tag_reg <= issue_rd ? {1'b1, op_reg == '0, op_reg == OP_LAST} : 3'b000;
         if (accept) begin
            base_reg <= base_in;
            dest_reg <= hv_dest;
            len_reg  <= len_clamped;
            off_reg  <= '0;
            done     <= 1'b0;
         end
         if (issue_rd) begin
            address <= base_reg[op_reg] + AW'(off_reg);
            op_reg  <= (op_reg == OP_LAST) ? '0 : op_reg + OPW'(1);
         end
         if (wr_start) begin
            address <= dest_reg + AW'(off_reg);
            data_wr <= k_data_out;
         end
         if (wr_end) off_reg <= off_inc;
         if (finish) done    <= 1'b1;
      end
   end

   // Tag shift register: delays each read tag by the DPRAM read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_pipe_reg <= '{default: '0};
      end else begin
         for (int i = RD_LATENCY - 1; i > 0; i--) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
         tag_pipe_reg[0] <= rd_tag_reg;
      end
   end

`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
   // Busy-cycle counter: cleared on accept, counts while done is low, saturates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        busy_cycles <= '0;
      else if (accept)                     busy_cycles <= '0;
      else if (!done && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_bind_nway_stream_mapper.sv
// Testbench for bind_nway_stream_mapper: two instances (N=2/L=1, N=4/L=3)
// with a DPRAM model, an XOR kernel model and queue-based scoreboards.
module tb_bind_nway_stream_mapper;

   localparam int AW = 20, DW = 32, MAXL = 4, LW = 3;
   localparam int NA = 2, LA = 1, NB = 4, LB = 3;

   typedef struct { logic [DW-1:0] data; logic first; logic last; } kexp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;
   typedef struct {
      int inst; logic [AW-1:0] b0, b1, b2, b3; logic [AW-1:0] dest;
      logic [LW-1:0] len; int kd; int exp_words;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   logic          valid_v [2];
   logic [AW-1:0] base_v  [2][4];
   logic [AW-1:0] dest_v  [2];
   logic [LW-1:0] len_v   [2];
   logic          kready_v[2];
   logic          early_v [2];
   int            kdelay_v[2];

   logic          done_o[2], we_n_o[2], kvalid_o[2], kfirst_o[2], klast_o[2];
   logic [AW-1:0] addr_o[2];
   logic [DW-1:0] wr_o[2], kdin_o[2];
`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
   logic [31:0]   busy_o[2];
`endif

   kexp_t kq[2][$];
   wexp_t wq[2][$];
   kexp_t mon_k;
   wexp_t mon_w;
   int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
   int kf_cyc[2], kl_cyc[2], wr_cyc[2], nwr[2], nlast[2];
   vec_t vt[5];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {a[11:0], 20'h0} ^ (32'h9E37_79B1 * {12'h0, a}) ^ 32'h1357_9BDF;
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int N = (gi == 0) ? NA : NB;
      localparam int L = (gi == 0) ? LA : LB;
      logic [N*AW-1:0] hv_base;
      logic [DW-1:0]   data_rd, k_data_out, acc, acc_nx, res;
      logic [AW-1:0]   rd_pipe [L];
      logic            k_done, early;
      int              cnt;

      always_comb for (int k = 0; k < N; k++) hv_base[k*AW +: AW] = base_v[gi][k];

      bind_nway_stream_mapper #(
         .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .NUM_OPERANDS(N),
         .MAX_HYPERVECTOR_LENGTH(MAXL), .RD_LATENCY(L)
      ) u_dut (
         .clk(clk), .reset_n(reset_n), .valid(valid_v[gi]), .hv_base(hv_base),
         .hv_dest(dest_v[gi]), .hv_len(len_v[gi]), .we_n(we_n_o[gi]),
         .address(addr_o[gi]), .data_wr(wr_o[gi]), .data_rd(data_rd),
         .done(done_o[gi]), .k_valid(kvalid_o[gi]), .k_first(kfirst_o[gi]),
         .k_last(klast_o[gi]), .k_data_in(kdin_o[gi]), .k_data_out(k_data_out),
         .k_ready(kready_v[gi]), .k_done(k_done)
`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
         , .busy_cycles(busy_o[gi])
`endif
      );

      // DPRAM model: data is a fixed function of the address, L cycles late
      always @(posedge clk) begin
         for (int k = L - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
         rd_pipe[0] <= addr_o[gi];
      end
      assign data_rd = pat(rd_pipe[L-1]);

      // XOR kernel model: result kdelay cycles after k_last; optional bogus
      // early k_done in the k_last cycle
      assign acc_nx     = (kfirst_o[gi] ? '0 : acc) ^ kdin_o[gi];
      assign early      = early_v[gi] && klast_o[gi];
      assign k_done     = (cnt == 1) || early;
      assign k_data_out = early ? 32'hDEAD_BEEF : res;
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            acc <= '0; res <= '0; cnt <= 0;
         end else begin
            if (cnt > 0) cnt <= cnt - 1;
            if (kvalid_o[gi]) begin
               acc <= acc_nx;
               if (klast_o[gi]) begin
                  res <= acc_nx;
                  cnt <= kdelay_v[gi];
               end
            end
         end
      end
   end

   always @(posedge clk) cyc++;

   // Monitor: pops scoreboards on kernel words and DPRAM writes
   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < 2; i++) begin
            if (kvalid_o[i]) begin
               if (kfirst_o[i]) kf_cyc[i] = cyc;
               if (klast_o[i]) begin
                  kl_cyc[i] = cyc;
                  nlast[i]++;
                  chk("grp_span", 64'(cyc - kf_cyc[i]), 64'((i == 0) ? NA - 1 : NB - 1));
               end
               if (kq[i].size() == 0) begin
                  total++; bad++;
                  $display("FAIL kword_extra inst=%0d: got %h want none", i, kdin_o[i]);
               end else begin
                  mon_k = kq[i].pop_front();
                  chk("kword", {kfirst_o[i], klast_o[i], kdin_o[i]}, {mon_k.first, mon_k.last, mon_k.data});
               end
            end else if (kfirst_o[i] || klast_o[i] || kdin_o[i] != '0) begin
               total++; bad++;
               $display("FAIL kidle inst=%0d: got f=%b l=%b d=%h want 0", i, kfirst_o[i], klast_o[i], kdin_o[i]);
            end
            if (!we_n_o[i]) begin
               wr_cyc[i] = cyc;
               nwr[i]++;
               $display("wr inst=%0d addr=%h data=%h", i, addr_o[i], wr_o[i]);
               if (wq[i].size() == 0) begin
                  total++; bad++;
                  $display("FAIL write_extra inst=%0d: got addr %h want none", i, addr_o[i]);
               end else begin
                  mon_w = wq[i].pop_front();
                  chk("write", {addr_o[i], wr_o[i]}, {mon_w.addr, mon_w.data});
               end
            end
         end
      end
   end

   task automatic push_exp(input int i, input logic [LW-1:0] len);
      int n, wc;
      logic [AW-1:0] a;
      logic [DW-1:0] d, x;
      n  = (i == 0) ? NA : NB;
      wc = (int'(len) > MAXL) ? MAXL : int'(len);
      for (int w = 0; w < wc; w++) begin
         x = '0;
         for (int op = 0; op < n; op++) begin
            a = base_v[i][op] + AW'(w);
            d = pat(a);
            x = x ^ d;
            kq[i].push_back('{d, op == 0, op == n - 1});
         end
         wq[i].push_back('{dest_v[i] + AW'(w), x});
      end
   endtask

   task automatic start(input int i, input logic [AW-1:0] b0, b1, b2, b3,
                        input logic [AW-1:0] dest, input logic [LW-1:0] len, input int kd);
      @(negedge clk);
      base_v[i][0] = b0; base_v[i][1] = b1; base_v[i][2] = b2; base_v[i][3] = b3;
      dest_v[i] = dest; len_v[i] = len; kdelay_v[i] = kd; valid_v[i] = 1'b1;
      acc_cyc = cyc;
      push_exp(i, len);
      $display("req inst=%0d base0=%h dest=%h len=%0d", i, b0, dest, len);
      @(negedge clk);
      valid_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int k;
      k = 0;
      while (!done_o[i] && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!done_o[i]) begin
         total++; bad++;
         $display("FAIL idle_timeout inst=%0d: done=%b want 1", i, done_o[i]);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      for (int i = 0; i < 2; i++) begin
         chk({nm, "_ctl"}, {done_o[i], we_n_o[i], kvalid_o[i], kfirst_o[i], klast_o[i]}, 5'b11000);
         chk({nm, "_addr"}, addr_o[i], {AW{1'b1}});
         chk({nm, "_data"}, {wr_o[i], kdin_o[i]}, '0);
      end
   endtask

   initial begin
      int nw0, n, r;
      vt[0] = '{1, 20'h01000, 20'h02000, 20'h03000, 20'h04000, 20'h05000, 3'd4, 1, 4};
      vt[1] = '{1, 20'h00010, 20'h00020, 20'h00030, 20'h00040, 20'h00080, 3'd7, 2, 4};
      vt[2] = '{1, 20'hFFFFE, 20'h00005, 20'h7FFFF, 20'hFFFFF, 20'hFFFFE, 3'd3, 4, 3};
      vt[3] = '{0, 20'h00044, 20'h00044, 20'h0, 20'h0, 20'h00009, 3'd2, 5, 2};
      vt[4] = '{0, 20'hFFFFF, 20'h00000, 20'h0, 20'h0, 20'h00123, 3'd5, 1, 4};
      for (int i = 0; i < 2; i++) begin
         valid_v[i] = 1'b0; kready_v[i] = 1'b1; early_v[i] = 1'b0; kdelay_v[i] = 1;
         dest_v[i] = '0; len_v[i] = '0;
         for (int k = 0; k < 4; k++) base_v[i][k] = '0;
         kf_cyc[i] = 0; kl_cyc[i] = 0; wr_cyc[i] = 0; nwr[i] = 0; nlast[i] = 0;
      end
      #1 reset_n = 1'b0;
      #1 chk_reset_vals("rst");
`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
      chk("rst_busy", busy_o[0], 0);
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Test 1: N=2, L=1, single word, exact latencies
      nw0 = nwr[0];
      start(0, 20'h00100, 20'h00200, 20'h0, 20'h0, 20'h00300, 3'd1, 3);
      @(negedge clk);
      chk("t1_addr0", addr_o[0], 20'h00100);
      @(negedge clk);
      chk("t1_addr1", addr_o[0], 20'h00200);
      wait_idle(0);
      chk("t1_kfirst_cyc", 64'(kf_cyc[0] - acc_cyc), 3);
      chk("t1_klast_cyc", 64'(kl_cyc[0] - acc_cyc), 4);
      chk("t1_write_cyc", 64'(wr_cyc[0] - kl_cyc[0]), 4);
      chk("t1_writes", 64'(nwr[0] - nw0), 1);
      chk("t1_idle", {done_o[0], we_n_o[0]}, 2'b11);

      // Table-driven requests (includes N=4, L=3, hv_len=4 and clamp/wrap)
      for (int v = 0; v < 5; v++) begin
         nw0 = nwr[vt[v].inst];
         start(vt[v].inst, vt[v].b0, vt[v].b1, vt[v].b2, vt[v].b3, vt[v].dest, vt[v].len, vt[v].kd);
         wait_idle(vt[v].inst);
         chk("tbl_words", 64'(nwr[vt[v].inst] - nw0), 64'(vt[v].exp_words));
      end

      // Test 3: zero length, done low for exactly two cycles
      nw0 = nwr[1];
      start(1, 20'h00AAA, 20'h00BBB, 20'h00CCC, 20'h00DDD, 20'h00EEE, 3'd0, 1);
      n = 0;
      while (!done_o[1] && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("t3_done_low", n, 2);
      chk("t3_writes", 64'(nwr[1] - nw0), 0);
`ifdef BIND_NWAY_MAPPER_PERF_CNT_EN
      chk("t3_busy", busy_o[1], 2);
`endif

      // Test 4: k_ready held low for 10 cycles after accept
      kready_v[0] = 1'b0;
      start(0, 20'h00400, 20'h00500, 20'h0, 20'h0, 20'h00600, 3'd1, 1);
      repeat (9) @(negedge clk);
      @(negedge clk);
      kready_v[0] = 1'b1;
      r = cyc;
      @(negedge clk);
      chk("t4_addr", addr_o[0], 20'h00400);
      chk("t4_addr_cyc", 64'(cyc - r), 1);
      wait_idle(0);
      chk("t4_kfirst_cyc", 64'(kf_cyc[0] - r), 2);

      // Test 5: early k_done with k_last must be ignored
      early_v[0] = 1'b1;
      start(0, 20'h00810, 20'h00820, 20'h0, 20'h0, 20'h00830, 3'd1, 2);
      wait_idle(0);
      early_v[0] = 1'b0;
      chk("t5_write_cyc", 64'(wr_cyc[0] - kl_cyc[0]), 3);

      // Test 6: reset during S_WAIT_DONE of word 2
      n = nlast[0];
      start(0, 20'h00900, 20'h00A00, 20'h0, 20'h0, 20'h00B00, 3'd4, 8);
      r = 0;
      while (nlast[0] < n + 3 && r < 200) begin
         @(negedge clk);
         r++;
      end
      chk("t6_reach_word2", 64'(nlast[0] - n), 3);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1 chk_reset_vals("t6_rst");
      kq[0].delete(); wq[0].delete(); kq[1].delete(); wq[1].delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      nw0 = nwr[0];
      repeat (12) @(negedge clk);
      chk("t6_no_write", 64'(nwr[0] - nw0), 0);
      start(0, 20'h00050, 20'h00060, 20'h0, 20'h0, 20'h00700, 3'd2, 1);
      wait_idle(0);
      chk("t6_restart_writes", 64'(nwr[0] - nw0), 2);

      for (int i = 0; i < 2; i++) begin
         chk("kq_empty", kq[i].size(), 0);
         chk("wq_empty", wq[i].size(), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
